// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, opcode/funct constants and control select codes
// for the multicycle MIPS control unit.
package mips_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_R_EXEC     = 5'd4,
        S_R_WB       = 5'd5,
        S_ADDI_EXEC  = 5'd6,
        S_ADDI_WB    = 5'd7,
        S_MEM_ADDR   = 5'd8,
        S_MEM_READ   = 5'd9,
        S_MEM_WAIT   = 5'd10,
        S_LW_WB      = 5'd11,
        S_MEM_WRITE  = 5'd12,
        S_BEQ        = 5'd13,
        S_BNE        = 5'd14,
        S_JUMP       = 5'd15,
        S_HALT       = 5'd16
    } state_t;

    typedef enum logic [2:0] {
        ALU_LOAD = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_INC  = 3'b100,
        ALU_NOT  = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_CMP  = 3'b111
    } alu_sel_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_INVALID = 2'b01;
    localparam logic [1:0] EXC_OVF     = 2'b10;

endpackage

// File: rtl/mips_control_unit_if.sv
// mips_control_unit_if: instruction/flag inputs and datapath control outputs between
// the control unit (master) and the datapath (slave).
interface mips_control_unit_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       ALU_zero;
    logic       ALU_overflow;
    logic       Dp_reset;
    logic       PC_load;
    logic       IorD;
    logic       wr;
    logic       IR_load;
    logic       MDR_load;
    logic       A_load;
    logic       B_load;
    logic       ALUOut_load;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [2:0] ALU_sel;
    logic [1:0] Exc_code;
    logic [4:0] State;

    modport master (
        input  Opcode, Funct, ALU_zero, ALU_overflow,
        output Dp_reset, PC_load, IorD, wr, IR_load, MDR_load, A_load, B_load,
               ALUOut_load, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
               PCSource, ALU_sel, Exc_code, State
    );

    modport slave (
        output Opcode, Funct, ALU_zero, ALU_overflow,
        input  Dp_reset, PC_load, IorD, wr, IR_load, MDR_load, A_load, B_load,
               ALUOut_load, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
               PCSource, ALU_sel, Exc_code, State
    );
endinterface

// File: rtl/mips_control_unit_alu_decoder.sv
// alu_decoder: maps an R-type funct field to an ALU function code, flags whether the
// funct is supported and whether signed overflow must trap for it.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output alu_sel_t   alu_sel,
    output logic       valid,
    output logic       ovf_checked
);
    always_comb begin
        alu_sel     = ALU_LOAD;
        valid       = 1'b1;
        ovf_checked = 1'b0;
        case (funct)
            FN_ADD: begin
                alu_sel     = ALU_ADD;
                ovf_checked = 1'b1;
            end
            FN_SUB: begin
                alu_sel     = ALU_SUB;
                ovf_checked = 1'b1;
            end
            FN_AND:  alu_sel = ALU_AND;
            FN_XOR:  alu_sel = ALU_XOR;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_control_unit.sv
// mips_control_unit: multicycle MIPS control FSM; Moore decode of state drives the datapath,
// with branch PC_load and the overflow trap out of the execute states as the Mealy exceptions.
module mips_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int RESET_HOLD = 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    mips_control_unit_if.master bus
);
    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] exc_q, exc_d;
    alu_sel_t   dec_sel;
    logic       dec_valid;
    logic       dec_ovf;

    alu_decoder u_alu_decoder (
        .funct       (bus.Funct),
        .alu_sel     (dec_sel),
        .valid       (dec_valid),
        .ovf_checked (dec_ovf)
    );

    // Asynchronous reset pulls state to RESET at once, so every write enable drops with Reset_n.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = '0;
        exc_d           = exc_q;
        bus.Dp_reset    = 1'b0;
        bus.PC_load     = 1'b0;
        bus.IorD        = 1'b0;
        bus.wr          = 1'b0;
        bus.IR_load     = 1'b0;
        bus.MDR_load    = 1'b0;
        bus.A_load      = 1'b0;
        bus.B_load      = 1'b0;
        bus.ALUOut_load = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = SRCB_B;
        bus.PCSource    = PCSRC_ALU;
        bus.ALU_sel     = ALU_LOAD;
        case (state_q)
            S_RESET: begin
                bus.Dp_reset = 1'b1;
                if (cnt_q >= HOLD_LAST) state_d = S_FETCH;
                else cnt_d = cnt_q + 4'd1;
            end
            S_FETCH: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                bus.IR_load = 1'b1;
                bus.ALUSrcB = SRCB_4;
                bus.ALU_sel = ALU_ADD;
                bus.PC_load = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                bus.A_load      = 1'b1;
                bus.B_load      = 1'b1;
                bus.ALUSrcB     = SRCB_IMM_SH;
                bus.ALU_sel     = ALU_ADD;
                bus.ALUOut_load = 1'b1;
                state_d         = S_HALT;
                exc_d           = EXC_INVALID;
                if ((bus.Opcode == OP_RTYPE && dec_valid) || bus.Opcode == OP_LW || bus.Opcode == OP_SW ||
                    bus.Opcode == OP_BEQ || bus.Opcode == OP_BNE || bus.Opcode == OP_J || bus.Opcode == OP_ADDI)
                    exc_d = exc_q;
                case (bus.Opcode)
                    OP_RTYPE: if (dec_valid) state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:  state_d = S_BEQ;
                    OP_BNE:  state_d = S_BNE;
                    OP_J:    state_d = S_JUMP;
                    OP_ADDI: state_d = S_ADDI_EXEC;
                    default: state_d = S_HALT;
                endcase
            end
            S_R_EXEC: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALU_sel     = dec_sel;
                bus.ALUOut_load = 1'b1;
                state_d         = (bus.ALU_overflow && dec_ovf) ? S_HALT : S_R_WB;
                exc_d           = (bus.ALU_overflow && dec_ovf) ? EXC_OVF : exc_q;
            end
            S_R_WB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDI_EXEC: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = SRCB_IMM;
                bus.ALU_sel     = ALU_ADD;
                bus.ALUOut_load = 1'b1;
                state_d         = bus.ALU_overflow ? S_HALT : S_ADDI_WB;
                exc_d           = bus.ALU_overflow ? EXC_OVF : exc_q;
            end
            S_ADDI_WB: begin
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = SRCB_IMM;
                bus.ALU_sel     = ALU_ADD;
                bus.ALUOut_load = 1'b1;
                state_d         = (bus.Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                bus.IorD = 1'b1;
                state_d  = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                bus.IorD     = 1'b1;
                bus.MDR_load = 1'b1;
                state_d      = S_LW_WB;
            end
            S_LW_WB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.IorD = 1'b1;
                bus.wr   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALU_sel  = ALU_SUB;
                bus.PCSource = PCSRC_ALUOUT;
                bus.PC_load  = (state_q == S_BEQ) ? bus.ALU_zero : !bus.ALU_zero;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSource = PCSRC_JUMP;
                bus.PC_load  = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    assign bus.Exc_code = exc_q;
    assign bus.State    = state_q;
endmodule

// File: tb/tb_mips_control_unit.sv
// tb_mips_control_unit: directed per-scenario checks of the multicycle control FSM.
module tb_mips_control_unit;
    localparam logic [4:0] ST_RESET = 5'd0,  ST_FETCH = 5'd1,  ST_FW   = 5'd2,  ST_DEC  = 5'd3;
    localparam logic [4:0] ST_REX   = 5'd4,  ST_RWB   = 5'd5,  ST_AEX  = 5'd6,  ST_AWB  = 5'd7;
    localparam logic [4:0] ST_MA    = 5'd8,  ST_MR    = 5'd9,  ST_MWT  = 5'd10, ST_LWB  = 5'd11;
    localparam logic [4:0] ST_MWR   = 5'd12, ST_BEQ   = 5'd13, ST_BNE  = 5'd14, ST_J    = 5'd15;
    localparam logic [4:0] ST_HALT  = 5'd16;

    logic Clk = 1'b0;
    logic Reset_n = 1'b1;
    int errors = 0;
    int checks = 0;

    mips_control_unit_if bus();

    mips_control_unit #(.RESET_HOLD(1)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.master)
    );

    always #5 Clk = ~Clk;

    task automatic cyc;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset;
        Reset_n = 1'b0;
        repeat (2) cyc();
        Reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset;
        #2 Reset_n = 1'b0;
        repeat (3) cyc();
        checks++; if (bus.State !== ST_RESET) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.State, ST_RESET); end
        checks++; if (bus.Dp_reset !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", bus.Dp_reset); end
        checks++; if (bus.Exc_code !== 2'b00) begin errors++; $display("FAIL reset_exc: got %b want 00", bus.Exc_code); end
        checks++; if (bus.PC_load !== 1'b0 || bus.wr !== 1'b0 || bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_we: got pc=%b wr=%b rw=%b want 0", bus.PC_load, bus.wr, bus.RegWrite); end
        Reset_n = 1'b1;
        #1;
        checks++; if (bus.Dp_reset !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b want 1", bus.Dp_reset); end
        cyc();
        checks++; if (bus.State !== ST_FETCH) begin errors++; $display("FAIL reset_exit: got %0d want %0d", bus.State, ST_FETCH); end
        checks++; if (bus.Dp_reset !== 1'b0 || bus.PC_load !== 1'b0) begin errors++; $display("FAIL reset_fetch: got dp=%b pc=%b want 0 0", bus.Dp_reset, bus.PC_load); end
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic ovf, input logic [2:0] exp_sel, input logic halts);
        logic [4:0] seq [4] = '{ST_FETCH, ST_FW, ST_DEC, ST_REX};
        bus.Opcode = 6'h00; bus.Funct = fn; bus.ALU_overflow = ovf;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.State !== seq[i]) begin errors++; $display("FAIL r_seq%0d: got %0d want %0d", i, bus.State, seq[i]); end
            checks++; if (bus.RegWrite !== 1'b0 || bus.RegDst !== 1'b0) begin errors++; $display("FAIL r_early_wb%0d: got rw=%b rd=%b want 0", i, bus.RegWrite, bus.RegDst); end
            checks++; if (bus.PC_load !== (i == 1)) begin errors++; $display("FAIL r_pcload%0d: got %b want %b", i, bus.PC_load, i == 1); end
            if (i == 3) begin
                checks++; if (bus.ALU_sel !== exp_sel || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b00 || bus.ALUOut_load !== 1'b1) begin
                    errors++; $display("FAIL r_exec: got sel=%b srca=%b srcb=%b ld=%b want sel=%b 1 00 1", bus.ALU_sel, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOut_load, exp_sel); end
            end
            cyc();
        end
        if (halts) begin
            checks++; if (bus.State !== ST_HALT || bus.Exc_code !== 2'b10) begin errors++; $display("FAIL r_ovf_halt: got st=%0d exc=%b want %0d 10", bus.State, bus.Exc_code, ST_HALT); end
            checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL r_ovf_rw: got %b want 0", bus.RegWrite); end
            do_reset();
        end else begin
            checks++; if (bus.State !== ST_RWB || bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b1 || bus.MemtoReg !== 1'b0) begin
                errors++; $display("FAIL r_wb: got st=%0d rw=%b rd=%b m2r=%b want %0d 1 1 0", bus.State, bus.RegWrite, bus.RegDst, bus.MemtoReg, ST_RWB); end
            cyc();
            checks++; if (bus.State !== ST_FETCH || bus.Exc_code !== 2'b00) begin errors++; $display("FAIL r_return: got st=%0d exc=%b want %0d 00", bus.State, bus.Exc_code, ST_FETCH); end
        end
    endtask

    task automatic test_lw;
        logic [4:0] seq [7] = '{ST_FETCH, ST_FW, ST_DEC, ST_MA, ST_MR, ST_MWT, ST_LWB};
        bus.Opcode = 6'h23; bus.ALU_overflow = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++; if (bus.State !== seq[i]) begin errors++; $display("FAIL lw_seq%0d: got %0d want %0d", i, bus.State, seq[i]); end
            checks++; if (bus.IorD !== (i == 4 || i == 5)) begin errors++; $display("FAIL lw_iord%0d: got %b want %b", i, bus.IorD, i == 4 || i == 5); end
            checks++; if (bus.MDR_load !== (i == 5) || bus.wr !== 1'b0) begin errors++; $display("FAIL lw_mdr%0d: got mdr=%b wr=%b want %b 0", i, bus.MDR_load, bus.wr, i == 5); end
            checks++; if (bus.RegWrite !== (i == 6) || bus.MemtoReg !== (i == 6)) begin errors++; $display("FAIL lw_wb%0d: got rw=%b m2r=%b want %b", i, bus.RegWrite, bus.MemtoReg, i == 6); end
            if (i == 6) begin
                checks++; if (bus.RegDst !== 1'b0) begin errors++; $display("FAIL lw_regdst: got %b want 0", bus.RegDst); end
            end
            cyc();
        end
        checks++; if (bus.State !== ST_FETCH) begin errors++; $display("FAIL lw_return: got %0d want %0d", bus.State, ST_FETCH); end
    endtask

    task automatic test_sw;
        logic [4:0] seq [5] = '{ST_FETCH, ST_FW, ST_DEC, ST_MA, ST_MWR};
        bus.Opcode = 6'h2B;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.State !== seq[i]) begin errors++; $display("FAIL sw_seq%0d: got %0d want %0d", i, bus.State, seq[i]); end
            checks++; if (bus.wr !== (i == 4) || bus.RegWrite !== 1'b0) begin errors++; $display("FAIL sw_wr%0d: got wr=%b rw=%b want %b 0", i, bus.wr, bus.RegWrite, i == 4); end
            if (i == 3) begin
                checks++; if (bus.ALUSrcB !== 2'b10 || bus.ALU_sel !== 3'b001) begin errors++; $display("FAIL sw_addr: got srcb=%b sel=%b want 10 001", bus.ALUSrcB, bus.ALU_sel); end
            end
            cyc();
        end
        checks++; if (bus.State !== ST_FETCH) begin errors++; $display("FAIL sw_return: got %0d want %0d", bus.State, ST_FETCH); end
    endtask

    task automatic test_branch(input logic [5:0] op, input logic zero, input logic [4:0] exp_st, input logic exp_pc);
        bus.Opcode = op; bus.ALU_zero = zero;
        repeat (3) cyc();
        checks++; if (bus.State !== exp_st) begin errors++; $display("FAIL br_state_%0h_%b: got %0d want %0d", op, zero, bus.State, exp_st); end
        checks++; if (bus.PC_load !== exp_pc) begin errors++; $display("FAIL br_pcload_%0h_%b: got %b want %b", op, zero, bus.PC_load, exp_pc); end
        checks++; if (bus.PCSource !== 2'b01 || bus.ALU_sel !== 3'b010 || bus.ALUSrcA !== 1'b1) begin
            errors++; $display("FAIL br_ctl_%0h_%b: got pcs=%b sel=%b srca=%b want 01 010 1", op, zero, bus.PCSource, bus.ALU_sel, bus.ALUSrcA); end
        cyc();
        checks++; if (bus.State !== ST_FETCH) begin errors++; $display("FAIL br_return_%0h: got %0d want %0d", op, bus.State, ST_FETCH); end
        bus.ALU_zero = 1'b0;
    endtask

    task automatic test_jump;
        bus.Opcode = 6'h02;
        repeat (3) cyc();
        checks++; if (bus.State !== ST_J || bus.PC_load !== 1'b1 || bus.PCSource !== 2'b10) begin
            errors++; $display("FAIL jump: got st=%0d pc=%b pcs=%b want %0d 1 10", bus.State, bus.PC_load, bus.PCSource, ST_J); end
        cyc();
        checks++; if (bus.State !== ST_FETCH) begin errors++; $display("FAIL jump_return: got %0d want %0d", bus.State, ST_FETCH); end
    endtask

    task automatic test_addi(input logic ovf);
        bus.Opcode = 6'h08; bus.ALU_overflow = ovf;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL addi_rw%0d: got %b want 0", i, bus.RegWrite); end
            cyc();
        end
        checks++; if (bus.State !== ST_AEX || bus.ALUSrcB !== 2'b10 || bus.ALU_sel !== 3'b001) begin
            errors++; $display("FAIL addi_exec: got st=%0d srcb=%b sel=%b want %0d 10 001", bus.State, bus.ALUSrcB, bus.ALU_sel, ST_AEX); end
        cyc();
        if (ovf) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (bus.State !== ST_HALT || bus.Exc_code !== 2'b10) begin errors++; $display("FAIL addi_halt%0d: got st=%0d exc=%b want %0d 10", i, bus.State, bus.Exc_code, ST_HALT); end
                checks++; if (bus.RegWrite !== 1'b0 || bus.PC_load !== 1'b0 || bus.wr !== 1'b0) begin errors++; $display("FAIL addi_halt_we%0d: got rw=%b pc=%b wr=%b want 0", i, bus.RegWrite, bus.PC_load, bus.wr); end
                cyc();
            end
            do_reset();
            checks++; if (bus.Exc_code !== 2'b00 || bus.State !== ST_FETCH) begin errors++; $display("FAIL addi_recover: got exc=%b st=%0d want 00 %0d", bus.Exc_code, bus.State, ST_FETCH); end
            bus.ALU_overflow = 1'b0;
        end else begin
            checks++; if (bus.State !== ST_AWB || bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b0 || bus.MemtoReg !== 1'b0) begin
                errors++; $display("FAIL addi_wb: got st=%0d rw=%b rd=%b m2r=%b want %0d 1 0 0", bus.State, bus.RegWrite, bus.RegDst, bus.MemtoReg, ST_AWB); end
            cyc();
        end
    endtask

    task automatic test_invalid(input logic [5:0] op, input logic [5:0] fn);
        bus.Opcode = op; bus.Funct = fn;
        repeat (2) cyc();
        checks++; if (bus.State !== ST_DEC || bus.Exc_code !== 2'b00) begin errors++; $display("FAIL inv_decode_%0h: got st=%0d exc=%b want %0d 00", op, bus.State, bus.Exc_code, ST_DEC); end
        cyc();
        checks++; if (bus.State !== ST_HALT || bus.Exc_code !== 2'b01) begin errors++; $display("FAIL inv_halt_%0h: got st=%0d exc=%b want %0d 01", op, bus.State, bus.Exc_code, ST_HALT); end
        cyc();
        checks++; if (bus.State !== ST_HALT || bus.Exc_code !== 2'b01 || bus.PC_load !== 1'b0) begin
            errors++; $display("FAIL inv_hold_%0h: got st=%0d exc=%b pc=%b want %0d 01 0", op, bus.State, bus.Exc_code, bus.PC_load, ST_HALT); end
        do_reset();
    endtask

    task automatic test_reset_mid_write;
        bus.Opcode = 6'h2B;
        repeat (4) cyc();
        checks++; if (bus.State !== ST_MWR || bus.wr !== 1'b1) begin errors++; $display("FAIL midw_pre: got st=%0d wr=%b want %0d 1", bus.State, bus.wr, ST_MWR); end
        #1 Reset_n = 1'b0;
        #1;
        checks++; if (bus.wr !== 1'b0 || bus.Dp_reset !== 1'b1 || bus.State !== ST_RESET) begin
            errors++; $display("FAIL midw_abort: got wr=%b dp=%b st=%0d want 0 1 %0d", bus.wr, bus.Dp_reset, bus.State, ST_RESET); end
        cyc();
        Reset_n = 1'b1;
        cyc();
        checks++; if (bus.State !== ST_FETCH) begin errors++; $display("FAIL midw_restart: got %0d want %0d", bus.State, ST_FETCH); end
    endtask

    initial begin
        bus.Opcode = 6'h00; bus.Funct = 6'h20; bus.ALU_zero = 1'b0; bus.ALU_overflow = 1'b0;
        test_reset();
        test_rtype(6'h20, 1'b0, 3'b001, 1'b0);
        test_rtype(6'h22, 1'b0, 3'b010, 1'b0);
        test_rtype(6'h24, 1'b1, 3'b011, 1'b0);
        test_rtype(6'h26, 1'b0, 3'b110, 1'b0);
        test_rtype(6'h22, 1'b1, 3'b010, 1'b1);
        test_lw();
        test_sw();
        test_branch(6'h04, 1'b1, ST_BEQ, 1'b1);
        test_branch(6'h04, 1'b0, ST_BEQ, 1'b0);
        test_branch(6'h05, 1'b1, ST_BNE, 1'b0);
        test_branch(6'h05, 1'b0, ST_BNE, 1'b1);
        test_jump();
        test_addi(1'b0);
        test_addi(1'b1);
        test_invalid(6'h3F, 6'h20);
        test_invalid(6'h00, 6'h21);
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
